// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, execute redirect and decode hand-off.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, opcode, f3, f7, misalign_err,
    input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, opcode, f3, f7, misalign_err,
    output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, 2-entry buffer toward decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a HALT state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
`ifdef FETCH_MISALIGN_TRAP_EN
    , HALT
`endif
  } state_t;

  state_t      state_reg;
  state_t      redirect_state;
  state_t      drain_state;
  logic [31:0] pc_reg;
  logic [31:0] addr_reg;
  logic [31:0] target;
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic        misalign_reg;
  logic        bad_redirect;
  logic        valid;
  logic        push;
  logic        pop;

  assign target = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad_redirect   = |bus.redirect_pc[1:0];
  assign redirect_state = bad_redirect ? HALT : IDLE;
  // A trap raised while a request was in flight parks in HALT once DROP drains it.
  assign drain_state    = misalign_reg ? HALT : IDLE;
`else
  assign bad_redirect   = 1'b0;
  assign redirect_state = IDLE;
  assign drain_state    = IDLE;
`endif

  assign valid = (count_reg != 2'd0);
  assign push  = (state_reg == WAIT) && bus.imem_ack && !bus.redirect;
  assign pop   = valid && bus.id_ready;

  always_comb begin
    count_next = count_reg;
    if (bus.redirect) begin
      count_next = 2'd0;
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr_reg] <= bus.imem_rdata;
      buf_pc[wr_ptr_reg]    <= pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      addr_reg     <= RESET_PC;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (bus.redirect) begin
        wr_ptr_reg   <= 1'b0;
        rd_ptr_reg   <= 1'b0;
        pc_reg       <= target;
        misalign_reg <= bad_redirect;
        // The outstanding request keeps its address; its data is thrown away in DROP.
        if ((state_reg == WAIT || state_reg == DROP) && !bus.imem_ack) begin
          state_reg <= DROP;
        end else begin
          state_reg <= redirect_state;
        end
      end else begin
        if (push) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        case (state_reg)
          IDLE: begin
            if (count_reg != 2'd2) begin
              state_reg <= WAIT;
              addr_reg  <= pc_reg;
            end
          end
          WAIT: begin
            if (bus.imem_ack) begin
              pc_reg   <= pc_reg + 32'd4;
              addr_reg <= pc_reg + 32'd4;
              if (count_next == 2'd2) state_reg <= IDLE;
            end
          end
          DROP: begin
            if (bus.imem_ack) state_reg <= drain_state;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.imem_req     = (state_reg == WAIT) || (state_reg == DROP);
  assign bus.imem_addr    = addr_reg;
  assign bus.id_valid     = valid;
  assign bus.id_instr     = valid ? buf_instr[rd_ptr_reg] : NOP_INSTR;
  assign bus.id_pc        = valid ? buf_pc[rd_ptr_reg] : pc_reg;
  assign bus.opcode       = bus.id_instr[6:0];
  assign bus.f3           = bus.id_instr[14:12];
  assign bus.f7           = bus.id_instr[31:25];
  assign bus.misalign_err = misalign_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder, stream-level reference model and head monitor.
// Expectations follow FETCH_MISALIGN_TRAP_EN when the build defines it.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      exp_q[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          ack_count = 0;
  int          pop_count = 0;
  int          min_delay = 0;
  int          max_delay = 0;
  logic [31:0] exp_pc    = RESET_PC;
  bit          stale     = 1'b0;
  bit          halted    = 1'b0;
  bit          exp_mis   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: expected event did not occur at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: each new request is acked after a random number of wait cycles.
  initial begin
    bit in_flight;
    int wait_cnt;
    in_flight = 1'b0;
    wait_cnt = 0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.imem_ack = 1'b0;
        in_flight = 1'b0;
      end else if (bus.imem_req) begin
        if (!in_flight) begin
          in_flight = 1'b1;
          wait_cnt = $urandom_range(max_delay, min_delay);
        end
        if (wait_cnt == 0) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = bus.imem_addr ^ KEY;
          in_flight = 1'b0;
        end else begin
          bus.imem_ack = 1'b0;
          wait_cnt--;
        end
      end else begin
        bus.imem_ack = 1'b0;
      end
    end
  end

  // Reference model: the stream is consecutive words from the last redirect target;
  // a redirect empties it and voids any request still in flight.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        exp_pc = RESET_PC;
        stale = 1'b0;
        halted = 1'b0;
        exp_mis = 1'b0;
      end else if (bus.redirect) begin
        exp_q.delete();
        stale = bus.imem_req && !bus.imem_ack;
        if (bus.imem_req && bus.imem_ack) ack_count++;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (bus.redirect_pc[1:0] != 2'b00) begin
          halted = 1'b1;
          exp_mis = 1'b1;
        end else begin
          halted = 1'b0;
          exp_mis = 1'b0;
          exp_pc = bus.redirect_pc;
        end
`else
        exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
      end else if (bus.imem_req && bus.imem_ack) begin
        ack_count++;
        if (stale) begin
          stale = 1'b0;
        end else if (halted) begin
          fail_now("fetch_while_halted");
        end else begin
          chk("fetch_addr", bus.imem_addr, exp_pc);
          chk("no_overflow", {31'd0, exp_q.size() < 2}, 32'd1);
          e.pc = exp_pc;
          e.instr = exp_pc ^ KEY;
          exp_q.push_back(e);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  // Monitor: decode-side head compared against the oldest expected entry.
  initial begin
    entry_t h;
    forever begin
      @(negedge clk);
      chk("id_valid", {31'd0, bus.id_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("id_pc", bus.id_pc, h.pc);
        chk("id_instr", bus.id_instr, h.instr);
        chk("opcode", {25'd0, bus.opcode}, {25'd0, h.instr[6:0]});
        chk("f3", {29'd0, bus.f3}, {29'd0, h.instr[14:12]});
        chk("f7", {25'd0, bus.f7}, {25'd0, h.instr[31:25]});
        if (bus.id_ready) begin
          void'(exp_q.pop_front());
          pop_count++;
          $display("pop pc=0x%08h instr=0x%08h", h.pc, h.instr);
        end
      end else begin
        chk("empty_instr", bus.id_instr, NOP);
        chk("empty_opcode", {25'd0, bus.opcode}, 32'h13);
        chk("empty_f3", {29'd0, bus.f3}, 32'h0);
        chk("empty_f7", {25'd0, bus.f7}, 32'h0);
      end
      chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, exp_mis});
      if (halted && !stale) chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    bus.redirect = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.redirect = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == a) found = 1'b1;
    end
    if (!found) fail_now(name);
  endtask

  // Waits for imem_req to go low and then high again, and checks the new address.
  task automatic wait_new_req(input logic [31:0] a, input string name);
    bit seen_low = 1'b0;
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!bus.imem_req) seen_low = 1'b1;
      else if (seen_low) found = 1'b1;
    end
    if (found) chk(name, bus.imem_addr, a);
    else fail_now(name);
  endtask

  initial begin
    int a0;
    int p0;
    int n;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready = 1'b1;
    rst = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_id_instr", bus.id_instr, NOP);
    chk("rst_id_pc", bus.id_pc, RESET_PC);
    chk("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
    chk("rst_opcode", {25'd0, bus.opcode}, 32'h13);

    // First request and zero-wait streaming
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_not_yet", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, RESET_PC);
    repeat (5) tick();
    p0 = pop_count;
    repeat (10) tick();
    chk("stream_rate", pop_count - p0, 32'd10);

    // Backpressure: two words buffered, then fetch stalls
    bus.id_ready = 1'b0;
    do_reset();
    a0 = ack_count;
    repeat (12) tick();
    chk("bp_acks", ack_count - a0, 32'd2);
    @(negedge clk);
    chk("bp_req_low", {31'd0, bus.imem_req}, 32'd0);
    chk("bp_head_pc", bus.id_pc, 32'h0);
    tick();
    bus.id_ready = 1'b1;
    wait_new_req(32'h8, "bp_resume_addr");

    // Redirect while 0x4 is in flight
    min_delay = 3;
    max_delay = 3;
    do_reset();
    wait_req_addr(32'h4, "inflight_wait4");
    tick();
    pulse_redirect(32'h100);
    wait_new_req(32'h100, "inflight_target");

    // Redirect coincident with the ack of 0xC
    do_reset();
    wait_req_addr(32'hC, "coinc_waitC");
    repeat (3) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    @(negedge clk);
    chk("coinc_addr", bus.imem_addr, 32'hC);
    tick();
    bus.redirect = 1'b0;
    wait_new_req(32'h200, "coinc_target");

    // PC wrap
    min_delay = 0;
    max_delay = 0;
    tick();
    pulse_redirect(32'hFFFF_FFFC);
    wait_new_req(32'hFFFF_FFFC, "wrap_first");
    @(negedge clk);
    chk("wrap_req", {31'd0, bus.imem_req}, 32'd1);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Misaligned redirect
    min_delay = 2;
    max_delay = 2;
    do_reset();
    wait_req_addr(32'h4, "mis_wait4");
    tick();
    pulse_redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (6) tick();
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req) n++;
    end
    chk("halt_no_req", n, 32'd0);
    chk("halt_misalign", {31'd0, bus.misalign_err}, 32'd1);
    chk("halt_valid", {31'd0, bus.id_valid}, 32'd0);
    tick();
    pulse_redirect(32'h40);
    @(negedge clk);
    chk("resume_misalign", {31'd0, bus.misalign_err}, 32'd0);
    wait_new_req(32'h40, "resume_addr");
`else
    wait_new_req(32'h100, "mis_forced_addr");
    chk("mis_flag_zero", {31'd0, bus.misalign_err}, 32'd0);
`endif

    // Randomized traffic with redirects, backpressure and one mid-run reset
    min_delay = 0;
    max_delay = 3;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      tick();
      bus.id_ready = ($urandom_range(3, 0) != 0);
      bus.redirect = 1'b0;
      if (c == 700) begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
      end else if ($urandom_range(39, 0) == 0) begin
        bus.redirect = 1'b1;
        case ($urandom_range(7, 0))
          0: bus.redirect_pc = $urandom;
          1: bus.redirect_pc = 32'hFFFF_FFF8;
          default: bus.redirect_pc = {20'd0, $urandom_range(4095, 0)} & 32'hFFFF_FFFC;
        endcase
      end
    end
    tick();
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that generates the instruction stream consumed by `controller`. It owns the PC and issues word requests to instruction memory, with one request outstanding at a time. Returned words go into a 2-entry buffer, and the buffer head is presented to decode as a full instruction plus pre-sliced `opcode`/`f3`/`f7` fields. Branch/jump redirects from execute (`doBranch | doJump`) flush the stream and restart fetch at the new target.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, value driven on `id_instr` when the buffer is empty
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address; word-aligned; stable while `imem_req` is high
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `redirect`  in  1  taken branch or jump
- `redirect_pc`  in  32  redirect target
- `id_valid`  out  1  buffer head valid
- `id_ready`  in  1  decode accepts head this cycle
- `id_instr`  out  32  head instruction, or `NOP_INSTR` when empty
- `id_pc`  out  32  PC of head instruction
- `opcode`  out  7  `id_instr[6:0]`
- `f3`  out  3  `id_instr[14:12]`
- `f7`  out  7  `id_instr[31:25]`
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- **FSM states**
  - IDLE: no request outstanding.
  - WAIT: request outstanding; data is kept when acked.
  - DROP: request outstanding; data is discarded when acked.
  - HALT: macro builds only.
- **IDLE → WAIT:** taken when `count + 0 < 2` and no redirect. Assert `imem_req` with `imem_addr = pc`.
- **WAIT, ack without redirect:** push `{pc, imem_rdata}`, then `pc <= pc + 4`. Next state is WAIT if the buffer still has room after push/pop, else IDLE.
- **Redirect:** highest priority in every state.
  - Buffer is flushed (count ← 0) and `pc <= {redirect_pc[31:2], 2'b00}`.
  - In WAIT without same-cycle ack: go to DROP.
  - In WAIT with same-cycle ack: data is discarded; go to IDLE, then request the target.
  - In IDLE or DROP-with-ack: go to IDLE.
- **DROP:** hold `imem_req`/`imem_addr` until `imem_ack`, discard the data, go to IDLE. The next request uses the redirect target.
- **Buffer:** 2-entry circular buffer with 1-bit read/write pointers and a 2-bit count.
  - Pop when `id_valid & id_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full is impossible by construction: a request is never issued when count == 2.
- **Outputs:** `opcode`/`f3`/`f7` are slices of `id_instr`, so decode sees `NOP_INSTR` fields when empty.
- **PC arithmetic:** modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- **Reset values:**
  - `imem_req` = 0, `imem_addr` = `RESET_PC`
  - `id_valid` = 0, `id_instr` = `NOP_INSTR`, `id_pc` = `RESET_PC`
  - `misalign_err` = 0
  - FSM = IDLE, count = 0
- **Reset mid-request:** an ack arriving during or after reset is ignored. The bench must not return stale acks.
- **First request:** `imem_req` rises the first cycle after `rst` deasserts.
- **Ack timing:** `imem_ack` is legal in any cycle `imem_req` is high, including its first cycle.
- **Ack-to-decode latency:** 1 cycle (data visible on `id_valid` the cycle after ack).
- **Back-to-back requests:** a new request is issued the cycle after ack while the buffer has room. Zero-wait memory yields one instruction per cycle.
- **Redirect-to-request latency:** 1 cycle from IDLE; after the ack in DROP.
- **Flush timing:** `id_valid` drops the cycle after `redirect`. A head accepted in the redirect cycle counts as consumed.

## Configuration
- **`FETCH_MISALIGN_TRAP_EN` defined:**
  - A redirect with `redirect_pc[1:0] != 0` sets `misalign_err`, flushes the buffer and enters HALT.
  - If a request is outstanding, the FSM first drains it through DROP and then goes to HALT.
  - In HALT, `imem_req` and `id_valid` are 0.
  - Only an aligned redirect or `rst` clears `misalign_err` and resumes fetch.
- **Not defined:**
  - `redirect_pc[1:0]` is ignored (forced to 00) and HALT does not exist.
  - `misalign_err` is tied to 0.

## Test plan
- **Reset and streaming:** reset, zero-wait memory returning `addr ^ 32'hA5A5_0000`, `id_ready`=1 → `imem_addr` 0,4,8,…; `id_pc`/`id_instr` match one cycle after each ack; one instruction per cycle.
- **Backpressure:** `id_ready`=0 → exactly 2 acks taken, then `imem_req` low. Release `id_ready` → heads popped in order, fetch resumes at `0x8`.
- **Redirect in flight:** ack delay 3 cycles, `redirect` to `0x100` while waiting on `0x4` → `0x4` data never appears on `id_valid`; next `imem_addr` = `0x100`.
- **Redirect with ack:** redirect to `0x200` coincident with ack of `0xC` → no valid for `0xC`; next request at `0x200`.
- **PC wrap:** redirect to `0xFFFF_FFFC` → following request at `0x0000_0000`.
- **Misalign:** redirect to `0x102`.
  - Macro defined: `misalign_err`=1, no requests; redirect to `0x40` clears it and fetch starts at `0x40`.
  - Macro undefined: fetch at `0x100`, `misalign_err`=0.
